bram_trig_capture: RTL and testbench

//   Pre/post-trigger sample capture writer feeding port A of the shared dual-port block RAM.
//   - While armed, writes the incoming sample stream into the RAM as a circular buffer.
//   - On trigger, writes POST further samples, then freezes and reports where the frame lives.
//   - Readout logic on port B (other clock domain) consumes the frame using start_addr/length.

---
 rtl/bram_trig_capture.sv | 116 +++++++++++
 tb/tb_bram_trig_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_trig_capture.sv
// Pre/post-trigger capture writer for RAM port A: circular pre-trigger buffer,
// POST samples after the trigger, then freeze and report the frame location.
module bram_trig_capture #(
    parameter int DATA = 72,
    parameter int ADDR = 10,
    parameter int POST = 768
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arm,
    input  logic            abort,
    input  logic            trig,
    input  logic            s_valid,
    input  logic [DATA-1:0] s_data,
    output logic            ram_wr,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] trig_addr,
    output logic [ADDR-1:0] start_addr,
    output logic [ADDR:0]   length,
    output logic [1:0]      state_dbg
);
    localparam int D = 1 << ADDR;
    localparam logic [ADDR:0] POST_L    = (ADDR+1)'(POST);
    localparam logic [ADDR:0] PRE_MAX_L = (ADDR+1)'(D - POST);
    localparam bit SINGLE_POST = (POST == 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [ADDR-1:0] wptr;
    logic [ADDR:0]   pre_fill;
    logic [ADDR:0]   post_cnt;
    logic            accept;

    // Sample stream is valid-only: a sample transfers on every cycle s_valid is
    // high and there is no back-pressure; it is written only in ARMED/POST.
    assign accept    = s_valid && !abort && (state == ST_ARMED || state == ST_POST);
    assign busy      = (state == ST_ARMED) || (state == ST_POST);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wptr       <= '0;
            pre_fill   <= '0;
            post_cnt   <= '0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            length     <= '0;
        end else begin
            ram_wr <= accept;
            if (accept) begin
                ram_addr <= wptr;
                ram_din  <= s_data;
                wptr     <= wptr + 1'b1;
            end

            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state    <= ST_ARMED;
                            wptr     <= '0;
                            pre_fill <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            trig_addr <= wptr;
                            if (s_valid && SINGLE_POST) begin
                                // The trigger sample is also the final sample.
                                state      <= ST_DONE;
                                post_cnt   <= '0;
                                start_addr <= wptr - pre_fill[ADDR-1:0];
                                length     <= pre_fill + POST_L;
                            end else if (s_valid) begin
                                state    <= ST_POST;
                                post_cnt <= POST_L - 1'b1;
                            end else begin
                                state    <= ST_POST;
                                post_cnt <= POST_L;
                            end
                        end else if (s_valid && pre_fill != PRE_MAX_L) begin
                            pre_fill <= pre_fill + 1'b1;
                        end
                    end
                    ST_POST: begin
                        if (s_valid) begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == 1) begin
                                state      <= ST_DONE;
                                start_addr <= trig_addr - pre_fill[ADDR-1:0];
                                length     <= pre_fill + POST_L;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bram_trig_capture.sv
// Directed bench for bram_trig_capture with DATA=8, ADDR=4 (D=16), POST=6.
module tb_bram_trig_capture;
    localparam int DATA = 8;
    localparam int ADDR = 4;
    localparam int POST = 6;

    logic            clk;
    logic            rst_n;
    logic            arm;
    logic            abort;
    logic            trig;
    logic            s_valid;
    logic [DATA-1:0] s_data;
    logic            ram_wr;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_din;
    logic            busy;
    logic            done;
    logic [ADDR-1:0] trig_addr;
    logic [ADDR-1:0] start_addr;
    logic [ADDR:0]   length;
    logic [1:0]      state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    bram_trig_capture #(.DATA(DATA), .ADDR(ADDR), .POST(POST)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
        .s_valid(s_valid), .s_data(s_data), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .busy(busy), .done(done), .trig_addr(trig_addr),
        .start_addr(start_addr), .length(length), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are checked 1ns after the edge.
    task automatic drive(input logic a, input logic ab, input logic t,
                         input logic v, input logic [DATA-1:0] d);
        arm = a; abort = ab; trig = t; s_valid = v; s_data = d;
        @(posedge clk);
        #1;
        arm = 1'b0; abort = 1'b0; trig = 1'b0; s_valid = 1'b0; s_data = '0;
    endtask

    task automatic expect_wr(input string tag, input int addr, input int din);
        chk({tag, "_wr"}, 32'(ram_wr), 32'd1);
        chk({tag, "_addr"}, 32'(ram_addr), 32'(addr));
        chk({tag, "_din"}, 32'(ram_din), 32'(din));
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, "_wr"}, 32'(ram_wr), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_din"}, 32'(ram_din), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_trig_addr"}, 32'(trig_addr), 32'd0);
        chk({tag, "_start"}, 32'(start_addr), 32'd0);
        chk({tag, "_len"}, 32'(length), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; s_valid = 1'b0; s_data = '0;

        // 1: reset with inputs toggling, then activity before any arm
        for (int i = 0; i < 4; i++) begin
            s_valid = i[0]; trig = ~i[0]; s_data = 8'(i);
            @(posedge clk);
            #1;
        end
        expect_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
            chk("pre_arm_wr", 32'(ram_wr), 32'd0);
            chk("pre_arm_busy", 32'(busy), 32'd0);
        end

        // 2: basic capture, 3 pre samples, trigger with sample
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_arm_busy", 32'(busy), 32'd1);
        chk("t2_arm_wr", 32'(ram_wr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
            expect_wr("t2_pre", i, 8'h10 + i);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h13);
        expect_wr("t2_trig", 3, 8'h13);
        chk("t2_trig_addr", 32'(trig_addr), 32'd3);
        chk("t2_trig_state", 32'(state_dbg), 32'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h14 + i));
            expect_wr("t2_post", 4 + i, 8'h14 + i);
            chk("t2_post_done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_trig_addr_f", 32'(trig_addr), 32'd3);
        chk("t2_start", 32'(start_addr), 32'd0);
        chk("t2_len", 32'(length), 32'd9);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk("t2_frozen_wr", 32'(ram_wr), 32'd0);
        chk("t2_frozen_done", 32'(done), 32'd1);
        chk("t2_frozen_trig", 32'(trig_addr), 32'd3);

        // 3: pre_fill saturation and wrap-around
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t3_arm_done", 32'(done), 32'd0);
        chk("t3_arm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h20 + i));
            expect_wr("t3_pre", i % 16, 8'h20 + i);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        expect_wr("t3_trig", 4, 8'h40);
        chk("t3_trig_addr", 32'(trig_addr), 32'd4);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h41 + i));
            expect_wr("t3_post", 5 + i, 8'h41 + i);
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_start", 32'(start_addr), 32'd10);
        chk("t3_len", 32'(length), 32'd16);

        // 4: trigger without sample, gaps, trig ignored in POST
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h30);
        expect_wr("t4_pre0", 0, 8'h30);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h31);
        expect_wr("t4_pre1", 1, 8'h31);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("t4_trig_wr", 32'(ram_wr), 32'd0);
        chk("t4_trig_addr", 32'(trig_addr), 32'd2);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, (k == 2), 1'b0, 8'h00);
            chk("t4_gap_wr", 32'(ram_wr), 32'd0);
            chk("t4_gap_done", 32'(done), 32'd0);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h50 + k));
            expect_wr("t4_post", 2 + k, 8'h50 + k);
            chk("t4_post_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("t4_trig_addr_f", 32'(trig_addr), 32'd2);
        chk("t4_start", 32'(start_addr), 32'd0);
        chk("t4_len", 32'(length), 32'd8);

        // 5: abort during POST, then trig in IDLE, then abort beats arm
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h60);
        expect_wr("t5_pre", 0, 8'h60);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h61);
        expect_wr("t5_trig", 1, 8'h61);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h62);
        expect_wr("t5_post", 2, 8'h62);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h63);
        chk("t5_abort_wr", 32'(ram_wr), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_done", 32'(done), 32'd0);
        chk("t5_abort_state", 32'(state_dbg), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h64);
        chk("t5_idle_trig_wr", 32'(ram_wr), 32'd0);
        chk("t5_idle_trig_busy", 32'(busy), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h65);
        chk("t5_abort_arm_busy", 32'(busy), 32'd0);

        // 6: arm from DONE restarts wptr; async reset mid-POST
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h70);
        expect_wr("t6_trig", 0, 8'h70);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h71 + i));
            expect_wr("t6_post", 1 + i, 8'h71 + i);
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_start", 32'(start_addr), 32'd0);
        chk("t6_len", 32'(length), 32'd6);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80);
        chk("t6_rearm_wr", 32'(ram_wr), 32'd0);
        chk("t6_rearm_busy", 32'(busy), 32'd1);
        chk("t6_rearm_done", 32'(done), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h81);
        expect_wr("t6_restart", 0, 8'h81);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h82);
        expect_wr("t6_trig2", 1, 8'h82);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h83);
        expect_wr("t6_post2", 2, 8'h83);
        s_valid = 1'b1; s_data = 8'h84;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_zero("t6_async_rst");
        @(posedge clk);
        #1;
        chk("t6_rst_hold_wr", 32'(ram_wr), 32'd0);
        chk("t6_rst_hold_state", 32'(state_dbg), 32'd0);
        s_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
